// File: rtl/uart_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_reader
//
// Read-side consumer of the uart_fifo asynchronous FIFO. Runs on the FIFO's
// rd_clk. Pops one byte at a time and shifts it out as a UART frame:
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
//
// Parameters
//   CLK_FREQ   clk frequency in Hz
//   BAUD_RATE  line rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, must be >= 2
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk            clock (same as FIFO rd_clk)
//   rst_n          asynchronous active-low reset
//   tx_en          permits popping new bytes; an in-flight frame always ends
//   fifo_rd_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   fifo_rd_en     registered one-cycle pop strobe
//   tx             serial line, idle high
//   busy           high in every state except IDLE
//   tx_done        one-cycle pulse during the final stop-bit cycle
//
// FIFO handshake: !fifo_rd_empty acts as "valid" and fifo_rd_en as a
// one-cycle "take" strobe. The strobe is only raised from IDLE while valid is
// high, is held for exactly one cycle (POP), and the byte is captured one
// cycle later (LOAD), matching a FIFO without an output register.
// ----------------------------------------------------------------------------
module uart_tx_fifo_reader #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_rd_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  // Guarded so a degenerate divide still elaborates to a 1-bit counter.
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam bit            ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shift_reg, shift_d;
  logic          parity_bit, parity_d;
  logic          tx_d, busy_d, tx_done_d, fifo_rd_en_d;
  logic          baud_tc;

  assign baud_tc = (baud_cnt == BAUD_LAST);

  // --------------------------------------------------------------------------
  // State register (FSM state, datapath and all registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_d;
      bit_cnt    <= bit_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      tx         <= tx_d;
      busy       <= busy_d;
      tx_done    <= tx_done_d;
      fifo_rd_en <= fifo_rd_en_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // bit_cnt indexes data bits in DATA and is reused to count stop bits in
  // STOP; it wraps 7->0 on leaving DATA, so it is already zero for STOP.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    bit_d    = bit_cnt;
    shift_d  = shift_reg;
    parity_d = parity_bit;

    case (state)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_en && !fifo_rd_empty) begin
          state_d = S_POP;
        end
      end

      S_POP: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d  = fifo_rd_data;
        parity_d = ODD_PARITY ? ~(^fifo_rd_data) : (^fifo_rd_data);
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end

      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_tc) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_reg[7:1]};
          bit_d   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // Outputs are registered, so they are derived from the *next* state and
  // datapath values; each registered output then lines up with its state.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_d         = 1'b1;
    busy_d       = (state_d != S_IDLE);
    fifo_rd_en_d = (state_d == S_POP);
    tx_done_d    = (state_d == S_STOP) && (baud_d == BAUD_LAST) &&
                   (bit_d == STOP_LAST);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// ----------------------------------------------------------------------------
// Bench for uart_tx_fifo_reader. Three instances at CLKS_PER_BIT = 10:
//   k=0: no parity, 1 stop bit
//   k=1: even parity, 2 stop bits
//   k=2: odd parity, 2 stop bits
// The bench plays the FIFO for each instance. A frame-level model predicts
// {tx, busy, tx_done, fifo_rd_en} on every cycle from the frame's bit list;
// directed scenarios add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_reader;

  localparam int CPB = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [2:0] tx_en;
  logic [2:0] fifo_rd_empty = 3'b111;
  logic [7:0] fifo_rd_data [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] fifo_rd_en, tx, busy, tx_done;

  uart_tx_fifo_reader #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                        .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[0]),
    .fifo_rd_data(fifo_rd_data[0]), .fifo_rd_empty(fifo_rd_empty[0]),
    .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  uart_tx_fifo_reader #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                        .PARITY(2), .STOP_BITS(2)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[1]),
    .fifo_rd_data(fifo_rd_data[1]), .fifo_rd_empty(fifo_rd_empty[1]),
    .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  uart_tx_fifo_reader #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                        .PARITY(1), .STOP_BITS(2)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en[2]),
    .fifo_rd_data(fifo_rd_data[2]), .fifo_rd_empty(fifo_rd_empty[2]),
    .fifo_rd_en(fifo_rd_en[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2])
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model
  // --------------------------------------------------------------------------
  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int nbits(input int k);
    return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
  endfunction

  // Level of frame bit idx: start, data LSB first, parity, stop(s).
  function automatic logic fbit(input int k, input logic [7:0] b, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par_of(k) != 0) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += b[i];
      if (par_of(k) == 2) return (ones % 2 == 1);
      return (ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  // off = cycles since the pop strobe: 0 pop, 1 load, 2.. frame bits,
  // then one idle cycle before a new pop can be considered. -1 = idle.
  // Result packs {tx, busy, tx_done, fifo_rd_en}.
  function automatic logic [3:0] model_out(input int k, input int off,
                                           input logic [7:0] b);
    int flen;
    flen = nbits(k) * CPB;
    if (off < 0 || off == flen + 2) return 4'b1000;
    if (off == 0) return 4'b1101;
    if (off == 1) return 4'b1100;
    return {fbit(k, b, (off - 2) / CPB), 1'b1, (off == flen + 1), 1'b0};
  endfunction

  // bench-side FIFO storage and model state
  logic [7:0] mem [3][16];
  int wr_ptr [3] = '{0, 0, 0};
  int rd_ptr [3] = '{0, 0, 0};
  int off    [3] = '{-1, -1, -1};
  int pops   [3] = '{0, 0, 0};
  int dones  [3] = '{0, 0, 0};
  logic [7:0] frm_byte [3] = '{8'h00, 8'h00, 8'h00};
  logic [3:0] exp_v, act_v;

  // Compare process: outputs sampled on the falling edge, away from posedge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) off[k] = -1;
      exp_v = model_out(k, off[k], frm_byte[k]);
      act_v = {tx[k], busy[k], tx_done[k], fifo_rd_en[k]};
      check($sformatf("outputs_dut%0d", k), act_v, exp_v);
      if (tx_done[k]) dones[k]++;
      if (fifo_rd_en[k]) begin
        pops[k]++;
        if (rd_ptr[k] < wr_ptr[k]) begin
          fifo_rd_data[k] = mem[k][rd_ptr[k]];
          rd_ptr[k]++;
        end
      end
      fifo_rd_empty[k] = (rd_ptr[k] == wr_ptr[k]);
      if (off[k] >= 0)
        off[k] = (off[k] == nbits(k) * CPB + 2) ? -1 : off[k] + 1;
      if (off[k] < 0 && rst_n && tx_en[k] && !fifo_rd_empty[k]) begin
        off[k]      = 0;
        frm_byte[k] = mem[k][rd_ptr[k]];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic push(input int k, input logic [7:0] b);
    @(posedge clk);
    #2;
    mem[k][wr_ptr[k]] = b;
    wr_ptr[k]++;
  endtask

  // which: 0 = wait for tx low, 1 = wait for tx_done
  task automatic wait_ev(input string name, input int k, input int which,
                         input int limit);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? (tx[k] === 1'b0) : (tx_done[k] === 1'b1);
    end
    check(name, hit, 1'b1);
  endtask

  // Captures a frame: mid-bit samples of every frame bit, start and done cycles.
  task automatic grab(input int k, output logic [11:0] bits,
                      output int t_start, output int t_done);
    bits    = '1;
    t_start = -1;
    t_done  = -1;
    wait_ev("start_bit_seen", k, 0, 3000);
    if (tx[k] === 1'b0) begin
      t_start = cyc;
      for (int o = 1; o < nbits(k) * CPB; o++) begin
        @(negedge clk);
        if (o % CPB == CPB / 2) bits[o / CPB] = tx[k];
        if (tx_done[k]) t_done = cyc;
      end
    end
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  logic [11:0] b1, b2;
  int ts1, td1, ts2, td2, p0, d0;

  initial begin
    rst_n = 1'b0;
    tx_en = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", tx, 3'b111);
    check("reset_busy", busy, 3'b000);
    check("reset_tx_done", tx_done, 3'b000);
    check("reset_rd_en", fifo_rd_en, 3'b000);
    rst_n = 1'b1;
    tx_en = 3'b111;

    // Empty FIFO with tx_en high: no pops, line idle.
    repeat (1000) @(posedge clk);
    #2;
    check("empty_no_pop", pops[0], 0);
    check("empty_tx_idle", tx[0], 1'b1);
    check("empty_not_busy", busy[0], 1'b0);

    // Single byte 0x55, no parity, 1 stop bit.
    push(0, 8'h55);
    grab(0, b1, ts1, td1);
    check("b55_start", b1[0], 1'b0);
    check("b55_data", b1[8:1], 8'h55);
    check("b55_stop", b1[9], 1'b1);
    check("b55_done_at_100", td1 - ts1, 99);
    check("b55_one_pop", pops[0], 1);
    @(negedge clk);
    check("b55_busy_falls", busy[0], 1'b0);

    // Back-to-back 0xA3, 0x01.
    push(0, 8'hA3);
    push(0, 8'h01);
    grab(0, b1, ts1, td1);
    grab(0, b2, ts2, td2);
    check("b2b_first", b1[8:1], 8'hA3);
    check("b2b_second", b2[8:1], 8'h01);
    check("b2b_gap_3", ts2 - td1 - 1, 3);
    check("b2b_two_pops", pops[0], 3);

    // Even parity, 2 stop bits, 0x07.
    push(1, 8'h07);
    grab(1, b1, ts1, td1);
    check("even_data", b1[8:1], 8'h07);
    check("even_parity", b1[9], 1'b1);
    check("even_stops", b1[11:10], 2'b11);
    check("even_len_120", td1 - ts1, 119);

    // Odd parity, 2 stop bits, 0x07.
    push(2, 8'h07);
    grab(2, b1, ts1, td1);
    check("odd_data", b1[8:1], 8'h07);
    check("odd_parity", b1[9], 1'b0);
    check("odd_len_120", td1 - ts1, 119);

    // tx_en dropped mid-frame with two bytes queued.
    tx_en[0] = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    p0 = pops[0];
    d0 = dones[0];
    @(posedge clk);
    #2;
    tx_en[0] = 1'b1;
    wait_ev("txen_start_seen", 0, 0, 50);
    repeat (5) @(posedge clk);
    #2;
    tx_en[0] = 1'b0;
    wait_ev("txen_done_seen", 0, 1, 200);
    repeat (40) @(posedge clk);
    #2;
    check("txen_frame_done", dones[0] - d0, 1);
    check("txen_single_pop", pops[0] - p0, 1);
    check("txen_idle", busy[0], 1'b0);
    tx_en[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("txen_repop", fifo_rd_en[0], 1'b1);
    grab(0, b1, ts1, td1);
    check("txen_second_byte", b1[8:1], 8'h22);

    // Reset in the middle of a 0xFF frame.
    push(0, 8'hFF);
    wait_ev("rst_start_seen", 0, 0, 50);
    repeat (25) @(posedge clk);
    #2;
    check("rst_busy_before", busy[0], 1'b1);
    d0 = dones[0];
    p0 = pops[0];
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx[0], 1'b1);
    check("rst_async_busy", busy[0], 1'b0);
    check("rst_async_rd_en", fifo_rd_en[0], 1'b0);
    check("rst_async_done", tx_done[0], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    check("rst_no_done", dones[0] - d0, 0);
    check("rst_no_pop", pops[0] - p0, 0);
    check("rst_tx_idle", tx[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Read-side consumer of the uart_fifo asynchronous FIFO (32-bit write, 8-bit read); runs on the FIFO's rd_clk domain.
- Pops one byte at a time from the FIFO read port and serialises it as an 8N1-style UART frame, with optional parity and configurable stop bits.
- Pairs with the FIFO writer: words written on the wr side leave the chip as bytes on tx.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide); must be >= 2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  in  1  single clock; same clock as the FIFO rd_clk.
- rst_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  permits popping new bytes; an in-flight frame always completes.
- fifo_rd_data  in  8  FIFO rd_data; valid the cycle after fifo_rd_en (no output register).
- fifo_rd_empty  in  1  FIFO rd_empty.
- fifo_rd_en  out  1  registered one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the POP state until return to IDLE.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (async assert, release on clk): state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd_en=0, baud counter=0, bit counter=0, shift register=0. All outputs are registered.
- States and transitions:
  - IDLE: if tx_en && !fifo_rd_empty, set fifo_rd_en=1 and go to POP; otherwise stay.
  - POP (1 cycle): fifo_rd_en returns to 0; go to LOAD.
  - LOAD (1 cycle): capture fifo_rd_data into the shift register; compute the parity bit (even = XOR of the byte; odd = its inverse); go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The bit counter (3 bits) wraps 7->0 on exit.
  - PARITY: entered only if PARITY!=0; one bit time.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final stop cycle tx_done=1; the next state is IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and advances the bit or state at the terminal count, then resets to 0.
- fifo_rd_en is asserted exactly once per frame and never while fifo_rd_empty=1 in IDLE. Because the pop strobe is registered, it is never sampled during reset.
- Back-to-back frames: after STOP, IDLE (1) + POP (1) + LOAD (1) gives exactly 3 idle-high clk cycles before the next start bit.
- tx_en deasserted mid-frame: the current frame finishes normally; no new pop occurs until tx_en=1.
- FIFO goes empty after a pop: the current byte is still sent; the block then idles with tx=1.
- Reset asserted mid-frame: tx goes to 1 immediately (async), and the frame is abandoned. The popped byte is lost; this is accepted behaviour.
- busy=1 in every state except IDLE. tx_done and fifo_rd_en are never high in the same cycle.

Test Plan:
(All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10.)
1. Reset mid-frame while sending 0xFF (during a data bit) -> tx=1 and busy=0 in the same cycle; fifo_rd_en=0; no tx_done pulse.
2. FIFO holds 0x55, PARITY=0, STOP_BITS=1, tx_en=1 -> one fifo_rd_en pulse. tx shows start 0 (10 clk), then 1,0,1,0,1,0,1,0 (10 clk each), then stop 1 (10 clk). tx_done pulses 1 cycle at clk 100 of the frame; busy then falls.
3. FIFO holds 0xA3, 0x01 back-to-back -> two frames with exactly 3 idle-high cycles between the end of stop and the next start. Bytes arrive LSB first in order 0xA3 then 0x01, with exactly 2 fifo_rd_en pulses.
4. PARITY=2 with byte 0x07, then PARITY=1 with byte 0x07 -> parity bit = 1 (even) and 0 (odd). STOP_BITS=2 -> stop holds 20 clk; frame length 120 clk.
5. fifo_rd_empty=1 with tx_en=1 for 1000 cycles -> fifo_rd_en never asserts, tx stays 1, busy stays 0.
6. tx_en dropped 5 cycles into a frame with 2 bytes queued -> the first frame completes with tx_done; no second pop while tx_en=0. Re-asserting tx_en pops the second byte within 1 cycle.
